ym3438_slot_ring: RTL and testbench

//  SLOTS-deep x WIDTH-bit circulating slot register with two-phase (c1/c2) clocking and per-slot overwrite.
//  It replaces chains of per-bit shift registers for the 24-slot operator/channel state rings (phase, envelope, ...).
//  It also provides a slot counter with a frame sync and a chained serial debug unload of the ring head.

---
 rtl/ym3438_pkg.sv | 12 +
 rtl/ym3438_slot_ring_dbg.sv | 37 +++
 rtl/ym3438_slot_ring.sv | 72 +++++++
 tb/tb_ym3438_slot_ring.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ym3438_pkg.sv
// Shared constants and types for the YM3438 operator/channel slot rings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ym3438_pkg;

    // The chip time-multiplexes 6 channels x 4 operators over 24 slots.
    localparam int YM_SLOTS  = 24;
    localparam int YM_SLOT_W = $clog2(YM_SLOTS);

    typedef logic [YM_SLOT_W-1:0] ym_slot_t;

endpackage

// File: rtl/ym3438_slot_ring_dbg.sv
// Serial debug shifter: parallel-loads a tapped word and shifts it out MSB first along a daisy chain.
// Latency: a load on a c1 cycle is visible at dbg_out on the following MCLK.
// Backpressure: none; updates only on c1, otherwise holds.
module ym3438_slot_ring_dbg #(
    parameter int WIDTH = 10
) (
    input  logic             MCLK,
    input  logic             rst,
    input  logic             c1,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             dbg_in,
    output logic             dbg_out
);

    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] chain;

    // Next serial value: shift up by one and take the upstream bit at the bottom.
    // A 1-bit shifter degenerates to just the upstream bit.
    always_comb begin
        chain    = dsr << 1;
        chain[0] = dbg_in;
    end

    // Load ORs the tapped word over the shifted chain so upstream data is never dropped.
    always_ff @(posedge MCLK) begin
        if (rst) begin
            dsr <= '0;
        end else if (c1) begin
            dsr <= load ? (load_data | chain) : chain;
        end
    end

    assign dbg_out = dsr[WIDTH-1];

endmodule

// File: rtl/ym3438_slot_ring.sv
// Circulating SLOTS x WIDTH slot ring with input latch, slot counter/frame sync and debug tap.
// Latency: a word captured on c1 returns at data_out after exactly SLOTS c2 pulses.
// Backpressure: none; c1 updates the input latch, c2 advances ring and counter, both may coincide.
module ym3438_slot_ring
    import ym3438_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int SLOTS = YM_SLOTS,
    localparam int CW   = $clog2(SLOTS)
) (
    input  logic             MCLK,
    input  logic             rst,
    input  logic             c1,
    input  logic             c2,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] data_out,
    output logic [CW-1:0]    slot,
    output logic             sync,
    input  logic             dbg_load,
    input  logic             dbg_in,
    output logic             dbg_out
);

    localparam logic [CW-1:0] LAST_SLOT = CW'(SLOTS - 1);

    logic [WIDTH-1:0] v1;
    logic [WIDTH-1:0] mem [SLOTS];

    // Head of the ring is the oldest entry: the slot leaving this cycle.
    assign data_out = mem[SLOTS-1];

    // Frame marker derived straight from the counter.
    assign sync = (slot == '0);

    // c1 captures either new data or the recirculating head; c2 shifts the previous latch
    // value in. Both use pre-edge values, so a joint c1&c2 shifts the old latch content.
    always_ff @(posedge MCLK) begin
        if (rst) begin
            v1   <= '0;
            slot <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (c1) begin
                v1 <= wr_en ? wr_data : data_out;
            end
            if (c2) begin
                mem[0] <= v1;
                for (int i = 1; i < SLOTS; i++) begin
                    mem[i] <= mem[i-1];
                end
                // Explicit wrap keeps non-power-of-2 rings inside 0..SLOTS-1.
                slot <= (slot == LAST_SLOT) ? '0 : slot + CW'(1);
            end
        end
    end

    ym3438_slot_ring_dbg #(
        .WIDTH(WIDTH)
    ) u_dbg (
        .MCLK      (MCLK),
        .rst       (rst),
        .c1        (c1),
        .load      (dbg_load),
        .load_data (data_out),
        .dbg_in    (dbg_in),
        .dbg_out   (dbg_out)
    );

endmodule

// File: tb/tb_ym3438_slot_ring.sv
// Bench for the slot ring: four instances (two chained 10x24, a 10x5 and a 1x24) run in lockstep
// against a slot-ownership reference model, plus directed frame, overlap, reset and debug scenarios.
// Inputs change 1 ns after the active edge; outputs are sampled 1 ns after the active edge.
module tb_ym3438_slot_ring;

    logic MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    logic       rst = 1'b1;
    logic       c1 = 1'b0;
    logic       c2 = 1'b0;
    logic       wr_en = 1'b0;
    logic       dbg_load = 1'b0;
    logic       dbg_in0 = 1'b0;
    logic [9:0] wd0 = '0, wd1 = '0, wd5 = '0;
    logic       wdw1 = 1'b0;

    logic [9:0] do0, do1, do5;
    logic       dow1;
    logic [4:0] sl0, sl1, slw1;
    logic [2:0] sl5;
    logic       sy0, sy1, sy5, syw1;
    logic       dbo0, dbo1, dbo5, dbow1;

    ym3438_slot_ring #(.WIDTH(10), .SLOTS(24)) u0 (
        .MCLK(MCLK), .rst(rst), .c1(c1), .c2(c2), .wr_en(wr_en), .wr_data(wd0),
        .data_out(do0), .slot(sl0), .sync(sy0),
        .dbg_load(dbg_load), .dbg_in(dbg_in0), .dbg_out(dbo0));

    ym3438_slot_ring #(.WIDTH(10), .SLOTS(24)) u1 (
        .MCLK(MCLK), .rst(rst), .c1(c1), .c2(c2), .wr_en(wr_en), .wr_data(wd1),
        .data_out(do1), .slot(sl1), .sync(sy1),
        .dbg_load(dbg_load), .dbg_in(dbo0), .dbg_out(dbo1));

    ym3438_slot_ring #(.WIDTH(10), .SLOTS(5)) u5 (
        .MCLK(MCLK), .rst(rst), .c1(c1), .c2(c2), .wr_en(wr_en), .wr_data(wd5),
        .data_out(do5), .slot(sl5), .sync(sy5),
        .dbg_load(dbg_load), .dbg_in(dbg_in0), .dbg_out(dbo5));

    ym3438_slot_ring #(.WIDTH(1), .SLOTS(24)) uw1 (
        .MCLK(MCLK), .rst(rst), .c1(c1), .c2(c2), .wr_en(wr_en), .wr_data(wdw1),
        .data_out(dow1), .slot(slw1), .sync(syw1),
        .dbg_load(dbg_load), .dbg_in(dbg_in0), .dbg_out(dbow1));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: every slot number owns one value. The value shown at the head is the
    // value owned by the current slot; a c2 hands that slot the value held in the input latch.
    int m_val  [4][24];
    int m_v1   [4];
    int m_slot [4];
    int m_dsr  [4];

    function automatic int k_width(int k);
        return (k == 3) ? 1 : 10;
    endfunction

    function automatic int k_slots(int k);
        return (k == 2) ? 5 : 24;
    endfunction

    function automatic int k_wdata(int k);
        case (k)
            0:       return int'(wd0);
            1:       return int'(wd1);
            2:       return int'(wd5);
            default: return int'(wdw1);
        endcase
    endfunction

    function automatic int m_head(int k);
        return m_val[k][m_slot[k]];
    endfunction

    function automatic int m_dbg(int k);
        return (m_dsr[k] >> (k_width(k) - 1)) & 1;
    endfunction

    task automatic model_step();
        int head [4];
        int nd   [4];
        int din, mask, nv1;
        for (int k = 0; k < 4; k++) head[k] = m_head(k);
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                for (int s = 0; s < 24; s++) m_val[k][s] = 0;
                m_v1[k]   = 0;
                m_slot[k] = 0;
                nd[k]     = 0;
            end else begin
                mask = (1 << k_width(k)) - 1;
                din  = (k == 1) ? m_dbg(0) : int'(dbg_in0);
                if (c1) nd[k] = (((m_dsr[k] * 2) + din) & mask) | (dbg_load ? head[k] : 0);
                else    nd[k] = m_dsr[k];
                nv1 = c1 ? (wr_en ? k_wdata(k) : head[k]) : m_v1[k];
                if (c2) begin
                    m_val[k][m_slot[k]] = m_v1[k];
                    m_slot[k] = (m_slot[k] + 1) % k_slots(k);
                end
                m_v1[k] = nv1;
            end
        end
        for (int k = 0; k < 4; k++) m_dsr[k] = nd[k];
    endtask

    task automatic check_all();
        check("u0_data", 32'(do0), 32'(m_head(0)));
        check("u0_slot", 32'(sl0), 32'(m_slot[0]));
        check("u0_sync", 32'(sy0), 32'(m_slot[0] == 0));
        check("u0_dbg",  32'(dbo0), 32'(m_dbg(0)));
        check("u1_data", 32'(do1), 32'(m_head(1)));
        check("u1_slot", 32'(sl1), 32'(m_slot[1]));
        check("u1_sync", 32'(sy1), 32'(m_slot[1] == 0));
        check("u1_dbg",  32'(dbo1), 32'(m_dbg(1)));
        check("s5_data", 32'(do5), 32'(m_head(2)));
        check("s5_slot", 32'(sl5), 32'(m_slot[2]));
        check("s5_sync", 32'(sy5), 32'(m_slot[2] == 0));
        check("s5_dbg",  32'(dbo5), 32'(m_dbg(2)));
        check("w1_data", 32'(dow1), 32'(m_head(3)));
        check("w1_slot", 32'(slw1), 32'(m_slot[3]));
        check("w1_sync", 32'(syw1), 32'(m_slot[3] == 0));
        check("w1_dbg",  32'(dbow1), 32'(m_dbg(3)));
    endtask

    task automatic tick(input bit t1, input bit t2, input bit tr);
        c1  = t1;
        c2  = t2;
        rst = tr;
        @(posedge MCLK);
        model_step();
        #1;
        check_all();
    endtask

    task automatic phase(input bit wr);
        wr_en = wr;
        tick(1'b1, 1'b0, 1'b0);
        wr_en = 1'b0;
        tick(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int nsync;
        int s4;
        logic [19:0] exp_stream;

        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s < 24; s++) m_val[k][s] = 0;
            m_v1[k] = 0; m_slot[k] = 0; m_dsr[k] = 0;
        end

        // 1. Reset for three cycles while the phase enables toggle.
        for (int i = 0; i < 3; i++) tick(i[0], ~i[0], 1'b1);
        check("rst_data", 32'(do0), 32'h0);
        check("rst_slot", 32'(sl0), 32'h0);
        check("rst_sync", 32'(sy0), 32'h1);
        check("rst_dbg",  32'(dbo0), 32'h0);
        tick(1'b0, 1'b0, 1'b0);
        check("post_rst_slot", 32'(sl0), 32'h0);

        // 2. Write 10'h2A5 while slot 5 is at the head; it must come back every frame.
        while (m_slot[0] != 5) phase(1'b0);
        wd0 = 10'h2A5; wd1 = 10'h2A5; wd5 = 10'h2A5; wdw1 = 1'b1;
        phase(1'b1);
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 24; i++) begin
                phase(1'b0);
                if (m_slot[0] == 5) check("write_return", 32'(do0), 32'h2A5);
            end
        end

        // 3. Fill each slot with slot+1, then recirculate for three frames.
        for (int i = 0; i < 24; i++) begin
            wd0  = 10'(m_slot[0] + 1);
            wd1  = 10'($urandom);
            wd5  = 10'(m_slot[2] + 1);
            wdw1 = 1'($urandom);
            phase(1'b1);
        end
        nsync = 0;
        for (int i = 0; i < 72; i++) begin
            phase(1'b0);
            check("recirc", 32'(do0), 32'(sl0) + 32'd1);
            if (sy0) nsync++;
        end
        check("sync_count", 32'(nsync), 32'd3);

        // 4. Same-cycle c1&c2 with a write while the head holds 10'h0AA.
        s4 = m_slot[0];
        wd0 = 10'h0AA;
        phase(1'b1);
        for (int i = 0; i < 23; i++) phase(1'b0);
        check("overlap_head", 32'(do0), 32'h0AA);
        wd0 = 10'h155; wr_en = 1'b1;
        tick(1'b1, 1'b1, 1'b0);
        wr_en = 1'b0;
        tick(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 23; i++) begin
            if (i == 22) check("overlap_old_v1", 32'(do0), 32'(m_val[0][s4]));
            phase(1'b0);
        end
        check("overlap_emerge", 32'(do0), 32'h155);

        // Randomised traffic, including lone c1, lone c2, overlaps and occasional reset.
        for (int i = 0; i < 400; i++) begin
            wr_en    = 1'($urandom_range(0, 1));
            dbg_load = ($urandom_range(0, 7) == 0);
            dbg_in0  = 1'($urandom);
            wd0 = 10'($urandom); wd1 = 10'($urandom); wd5 = 10'($urandom); wdw1 = 1'($urandom);
            tick(1'($urandom), 1'($urandom), ($urandom_range(0, 59) == 0));
        end
        wr_en = 1'b0; dbg_load = 1'b0; dbg_in0 = 1'b0;

        // 5. Reset in the middle of a frame at slot 17.
        for (int i = 0; i < 30 && m_slot[0] != 17; i++) phase(1'b0);
        check("pre_midrst_slot", 32'(sl0), 32'd17);
        tick(1'b1, 1'b1, 1'b1);
        check("midrst_slot", 32'(sl0), 32'h0);
        for (int i = 0; i < 24; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            check("midrst_slot_seq", 32'(sl0), 32'(i));
            check("midrst_zero", 32'(do0), 32'h0);
            tick(1'b0, 1'b1, 1'b0);
        end

        // 6. Chained debug unload: u0 head 10'h3FF, u1 head 10'h001; u1 is downstream.
        wd0 = 10'h3FF; wd1 = 10'h001;
        phase(1'b1);
        for (int i = 0; i < 23; i++) phase(1'b0);
        check("dbg_head0", 32'(do0), 32'h3FF);
        check("dbg_head1", 32'(do1), 32'h001);
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'b0);
        dbg_load = 1'b1;
        tick(1'b1, 1'b0, 1'b0);
        dbg_load = 1'b0;
        exp_stream = {10'h001, 10'h3FF};
        for (int i = 0; i < 20; i++) begin
            check("dbg_stream", 32'(dbo1), 32'(exp_stream[19-i]));
            tick(1'b1, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
